uart_num_formatter: RTL and testbench

//   Upstream feeder of the framed UART string transmitter. Converts a binary value into the

---
 rtl/uart_num_formatter.sv | 172 +++++++++++++++++
 tb/tb_uart_num_formatter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_num_formatter.sv
// Formats an unsigned value as "<tag>=<decimal>" for the framed UART string transmitter.
// The value is converted by double-dabble, then packed and sent with one transmitter handshake.
module uart_num_formatter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NDIG        = 10,
  parameter int unsigned STR_W       = 1096,
  parameter int unsigned TIMEOUT_CLK = 10_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic [7:0]        tag,
  input  logic              fmt_req,
  output logic              fmt_busy,
  output logic              fmt_done,
  output logic              fmt_err,
  output logic [STR_W-1:0]  tx_string,
  output logic [7:0]        tx_length,
  output logic              tx_req,
  input  logic              tx_busy,
  input  logic              tx_done
);

  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned DIG_W = $clog2(NDIG);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLK);

  typedef enum logic [6:0] {
    S_IDLE = 7'b0000001,
    S_CONV = 7'b0000010,
    S_PACK = 7'b0000100,
    S_REQ  = 7'b0001000,
    S_WAIT = 7'b0010000,
    S_DONE = 7'b0100000,
    S_ERR  = 7'b1000000
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  value_q, value_d;
  logic [7:0]         tag_q, tag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic               started_q, started_d;
  logic [7:0]         len_q, len_d;
  logic [STR_W-1:0]   tx_string_q, tx_string_d;
  logic [7:0]         tx_length_q, tx_length_d;
  logic               tx_req_q, tx_req_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [3:0]         cur_digit;

  // Double-dabble correction: any nibble >= 5 would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign cur_digit = bcd_q[4*int'(dig_q) +: 4];

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    tag_d       = tag_q;
    bcd_d       = bcd_q;
    bit_cnt_d   = bit_cnt_q;
    dig_d       = dig_q;
    started_d   = started_q;
    len_d       = len_q;
    tx_string_d = tx_string_q;
    tx_length_d = tx_length_q;
    tx_req_d    = 1'b0;
    to_cnt_d    = to_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (fmt_req) begin
          value_d     = value;
          tag_d       = tag;
          bcd_d       = '0;
          bit_cnt_d   = '0;
          tx_string_d = '0;
          tx_length_d = '0;
          state_d     = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d     = {bcd_adj[BCD_W-2:0], value_q[DATA_W-1]};
        value_d   = value_q << 1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          dig_d     = DIG_W'(NDIG - 1);
          started_d = 1'b0;
          len_d     = 8'd2;
          state_d   = S_PACK;
        end
      end
      S_PACK: begin
        tx_string_d[7:0]  = tag_q;
        tx_string_d[15:8] = 8'h3D;
        // Leading zeros are skipped, but the units digit always goes out so 0 prints as "0".
        if (cur_digit != 4'd0 || started_q || dig_q == '0) begin
          tx_string_d[8*int'(len_q) +: 8] = {4'h3, cur_digit};
          len_d     = len_q + 8'd1;
          started_d = 1'b1;
        end
        dig_d = dig_q - DIG_W'(1);
        if (dig_q == '0) begin
          tx_length_d = len_q + 8'd1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (!tx_busy) begin
          tx_req_d = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done)                                     state_d = S_DONE;
        else if (to_cnt_q == TO_W'(TIMEOUT_CLK - 1))     state_d = S_ERR;
        else                                             to_cnt_d = to_cnt_q + TO_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      value_q     <= '0;
      tag_q       <= '0;
      bcd_q       <= '0;
      bit_cnt_q   <= '0;
      dig_q       <= '0;
      started_q   <= 1'b0;
      len_q       <= '0;
      tx_string_q <= '0;
      tx_length_q <= '0;
      tx_req_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      tag_q       <= tag_d;
      bcd_q       <= bcd_d;
      bit_cnt_q   <= bit_cnt_d;
      dig_q       <= dig_d;
      started_q   <= started_d;
      len_q       <= len_d;
      tx_string_q <= tx_string_d;
      tx_length_q <= tx_length_d;
      tx_req_q    <= tx_req_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign fmt_busy  = (state_q != S_IDLE);
  assign fmt_done  = (state_q == S_DONE);
  assign fmt_err   = (state_q == S_ERR);
  assign tx_string = tx_string_q;
  assign tx_length = tx_length_q;
  assign tx_req    = tx_req_q;

endmodule

// File: tb/tb_uart_num_formatter.sv
// Scoreboard bench for uart_num_formatter: expected payloads are queued at request time and
// compared by a monitor whenever the formatter raises tx_req.
module tb_uart_num_formatter;

  localparam int DATA_W      = 32;
  localparam int NDIG        = 10;
  localparam int STR_W       = 1096;
  localparam int TIMEOUT_CLK = 50;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] value = '0;
  logic [7:0]        tag = '0;
  logic              fmt_req = 1'b0;
  logic              fmt_busy, fmt_done, fmt_err, tx_req;
  logic [STR_W-1:0]  tx_string;
  logic [7:0]        tx_length;
  logic              tx_busy, tx_done = 1'b0;
  logic              model_busy = 1'b0, force_busy = 1'b0;
  bit                drop_done = 1'b0;

  assign tx_busy = model_busy | force_busy;

  uart_num_formatter #(
    .DATA_W(DATA_W), .NDIG(NDIG), .STR_W(STR_W), .TIMEOUT_CLK(TIMEOUT_CLK)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .value(value), .tag(tag), .fmt_req(fmt_req),
    .fmt_busy(fmt_busy), .fmt_done(fmt_done), .fmt_err(fmt_err), .tx_string(tx_string),
    .tx_length(tx_length), .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [STR_W-1:0] str;
    logic [7:0]       len;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   tx_req_cnt = 0, done_cnt = 0, err_cnt = 0;
  exp_t last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input logic [STR_W-1:0] act,
                           input logic [STR_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s string: got low %h expected low %h", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [STR_W-1:0] str2bus(input string s);
    logic [STR_W-1:0] b = '0;
    for (int k = 0; k < s.len(); k++) b[8*k +: 8] = s[k];
    return b;
  endfunction

  task automatic push_exp(input string s);
    exp_t e;
    e.str  = str2bus(s);
    e.len  = 8'(s.len());
    e.name = s;
    sb.push_back(e);
  endtask

  // Monitor: compares every transmitter request against the scoreboard head.
  initial begin
    logic prev_req = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (tx_req) begin
          tx_req_cnt++;
          check("tx_req_width", prev_req, 1'b0);
          check("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            last_exp = e;
            check({e.name, " len"}, tx_length, e.len);
            check_str(e.name, tx_string, e.str);
          end
        end
        if (fmt_done) begin
          done_cnt++;
          check("done_width", prev_done, 1'b0);
          check({last_exp.name, " len_at_done"}, tx_length, last_exp.len);
          check_str({last_exp.name, " at_done"}, tx_string, last_exp.str);
        end
        if (fmt_err) begin
          err_cnt++;
          check("err_width", prev_err, 1'b0);
          check({last_exp.name, " len_at_err"}, tx_length, last_exp.len);
        end
      end
      prev_req  = tx_req;
      prev_done = fmt_done;
      prev_err  = fmt_err;
    end
  end

  // Transmitter model: busy from the cycle after tx_req, tx_done 20 cycles after tx_req.
  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (tx_req && sys_rst_n) begin
        @(posedge sys_clk); #1;
        model_busy = 1'b1;
        if (drop_done) begin
          repeat (5) @(posedge sys_clk);
          #1 model_busy = 1'b0;
        end else begin
          repeat (19) @(posedge sys_clk);
          #1 tx_done = 1'b1;
          @(posedge sys_clk);
          #1 tx_done = 1'b0;
          model_busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] v, input logic [7:0] t);
    @(posedge sys_clk); #1;
    value   = v;
    tag     = t;
    fmt_req = 1'b1;
    @(posedge sys_clk); #1;
    fmt_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (fmt_busy && c < 3000) begin
      @(posedge sys_clk); #1;
      c++;
    end
    check({name, " idle_timeout"}, fmt_busy, 1'b0);
  endtask

  typedef struct {
    logic [DATA_W-1:0] v;
    logic [7:0]        t;
    string             s;
  } vec_t;

  vec_t vecs[4] = '{
    '{32'd7,         8'h42, "B=7"},
    '{32'd10,        8'h43, "C=10"},
    '{32'd100000,    8'h5A, "Z=100000"},
    '{32'd123456789, 8'h44, "D=123456789"}
  };

  initial begin
    int base_req, base_done, c;

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst fmt_busy", fmt_busy, 1'b0);
    check("rst tx_req", tx_req, 1'b0);
    check("rst tx_length", tx_length, 8'd0);
    check("rst tx_string_zero", tx_string == '0, 1'b1);
    sys_rst_n = 1'b1;

    // Value 0 prints a single digit
    base_done = done_cnt;
    push_exp("F=0");
    send(32'd0, 8'h46);
    wait_idle("zero");
    check("zero done_count", done_cnt, base_done + 1);

    // Interior zeros kept, tail bytes cleared
    base_req = tx_req_cnt;
    push_exp("F=1000");
    send(32'd1000, 8'h46);
    wait_idle("thousand");
    check("thousand tx_req_count", tx_req_cnt, base_req + 1);

    // Full-scale value and request-to-send latency
    push_exp("A=4294967295");
    @(posedge sys_clk); #1;
    value = 32'hFFFF_FFFF; tag = 8'h41; fmt_req = 1'b1;
    c = 0;
    while (!tx_req && c < 200) begin
      @(posedge sys_clk); #1;
      if (c == 0) fmt_req = 1'b0;
      c++;
    end
    check("max latency", c, 44);
    wait_idle("max");

    foreach (vecs[i]) begin
      push_exp(vecs[i].s);
      send(vecs[i].v, vecs[i].t);
      wait_idle(vecs[i].s);
    end

    // Transmitter busy holds off the request; requests while busy are ignored
    base_req  = tx_req_cnt;
    base_done = done_cnt;
    force_busy = 1'b1;
    push_exp("G=42");
    send(32'd42, 8'h47);
    repeat (30) @(posedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      send(32'd99, 8'h48);
      repeat (10) @(posedge sys_clk);
    end
    repeat (84) @(posedge sys_clk);
    #1;
    check("busy hold no_req", tx_req_cnt, base_req);
    check("busy hold fmt_busy", fmt_busy, 1'b1);
    force_busy = 1'b0;
    @(posedge sys_clk); #1;
    check("req_after_busy_release", tx_req, 1'b1);
    wait_idle("busy");
    repeat (60) @(posedge sys_clk);
    #1;
    check("busy single_done", done_cnt, base_done + 1);
    check("busy single_req", tx_req_cnt, base_req + 1);
    check("busy stays_idle", fmt_busy, 1'b0);

    // Timeout path: no tx_done
    base_done = done_cnt;
    drop_done = 1'b1;
    push_exp("T=5");
    send(32'd5, 8'h54);
    c = 0;
    while (!tx_req && c < 200) begin
      @(posedge sys_clk); #1;
      c++;
    end
    check("timeout tx_req_seen", tx_req, 1'b1);
    c = 0;
    while (!fmt_err && c < 200) begin
      @(posedge sys_clk); #1;
      c++;
    end
    check("timeout err_delay", c, TIMEOUT_CLK);
    wait_idle("timeout");
    check("timeout no_done", done_cnt, base_done);
    check("timeout err_count", err_cnt, 1);
    drop_done = 1'b0;
    repeat (10) @(posedge sys_clk);
    push_exp("U=65535");
    send(32'd65535, 8'h55);
    wait_idle("after_timeout");
    check("after_timeout done", done_cnt, base_done + 1);

    // Reset in the middle of conversion
    base_req = tx_req_cnt;
    send(32'd123, 8'h52);
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check("midrst fmt_busy", fmt_busy, 1'b0);
    check("midrst tx_req", tx_req, 1'b0);
    check("midrst tx_length", tx_length, 8'd0);
    check("midrst tx_string_zero", tx_string == '0, 1'b1);
    check("midrst done_err", {fmt_done, fmt_err}, 2'b00);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (100) @(posedge sys_clk);
    #1;
    check("midrst no_req", tx_req_cnt, base_req);
    check("midrst idle", fmt_busy, 1'b0);
    push_exp("R=5");
    send(32'd5, 8'h52);
    wait_idle("after_rst");

    repeat (5) @(posedge sys_clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
